// File: rtl/lcd_st_pkt_arbiter.sv
// Two-input Avalon-ST packet arbiter: one source owns the output from SOP through EOP, round-robin between packets.
// Optional per-source EOP counters (pkt_cnt0/pkt_cnt1) are built when LCD_PKT_ARB_CNT_EN is defined.
module lcd_st_pkt_arbiter #(
  parameter int   DATA_W  = 64,
  parameter int   EMPTY_W = 3,
  parameter int   CNT_W   = 16,
  parameter logic RR_INIT = 1'b0
) (
  input  logic               clk,
  input  logic               reset_n,
  output logic               in0_ready,
  input  logic               in0_valid,
  input  logic [DATA_W-1:0]  in0_data,
  input  logic               in0_startofpacket,
  input  logic               in0_endofpacket,
  input  logic [EMPTY_W-1:0] in0_empty,
  output logic               in1_ready,
  input  logic               in1_valid,
  input  logic [DATA_W-1:0]  in1_data,
  input  logic               in1_startofpacket,
  input  logic               in1_endofpacket,
  input  logic [EMPTY_W-1:0] in1_empty,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [DATA_W-1:0]  out_data,
  output logic               out_startofpacket,
  output logic               out_endofpacket,
  output logic [EMPTY_W-1:0] out_empty,
  output logic [1:0]         grant,
  output logic               err_orphan
`ifdef LCD_PKT_ARB_CNT_EN
  ,
  output logic [CNT_W-1:0]   pkt_cnt0,
  output logic [CNT_W-1:0]   pkt_cnt1
`endif
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t state_reg;
  logic   rr_ptr_reg;
  logic   err_orphan_reg;

  logic [1:0]         src_valid, src_sop, src_eop, src_ready, own, req, eop_xfer;
  logic [DATA_W-1:0]  src_data  [2];
  logic [EMPTY_W-1:0] src_empty [2];
  logic               idle, sel, flush;

  assign src_valid    = {in1_valid, in0_valid};
  assign src_sop      = {in1_startofpacket, in0_startofpacket};
  assign src_eop      = {in1_endofpacket, in0_endofpacket};
  assign src_data[0]  = in0_data;
  assign src_data[1]  = in1_data;
  assign src_empty[0] = in0_empty;
  assign src_empty[1] = in1_empty;

  assign idle = (state_reg == IDLE);
  assign own  = {state_reg == OWN1, state_reg == OWN0};
  assign sel  = own[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign req[gi]       = src_valid[gi] & src_sop[gi];
      // In IDLE only non-SOP beats are accepted, and only to discard them.
      assign src_ready[gi] = own[gi] ? out_ready : (idle & src_valid[gi] & ~src_sop[gi]);
      assign eop_xfer[gi]  = own[gi] & src_valid[gi] & out_ready & src_eop[gi];
    end
  endgenerate

  assign flush     = idle & (|(src_valid & ~src_sop));
  assign in0_ready = src_ready[0];
  assign in1_ready = src_ready[1];

  assign out_valid         = (|own) & src_valid[sel];
  assign out_data          = (|own) ? src_data[sel]  : '0;
  assign out_startofpacket = (|own) & src_sop[sel];
  assign out_endofpacket   = (|own) & src_eop[sel];
  assign out_empty         = (|own) ? src_empty[sel] : '0;
  assign grant             = own;
  assign err_orphan        = err_orphan_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      rr_ptr_reg     <= RR_INIT;
      err_orphan_reg <= 1'b0;
    end else begin
      err_orphan_reg <= flush;
      case (state_reg)
        IDLE: begin
          if (req[0] & req[1])
            state_reg <= rr_ptr_reg ? OWN1 : OWN0;
          else if (req[0])
            state_reg <= OWN0;
          else if (req[1])
            state_reg <= OWN1;
        end
        OWN0: begin
          if (eop_xfer[0]) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b1;
          end
        end
        OWN1: begin
          if (eop_xfer[1]) begin
            state_reg  <= IDLE;
            rr_ptr_reg <= 1'b0;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LCD_PKT_ARB_CNT_EN
  logic [CNT_W-1:0] cnt_reg [2];

  // Counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 2; i++) cnt_reg[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++)
        if (eop_xfer[i]) cnt_reg[i] <= cnt_reg[i] + CNT_W'(1);
    end
  end

  assign pkt_cnt0 = cnt_reg[0];
  assign pkt_cnt1 = cnt_reg[1];
`endif

endmodule

// File: tb/tb_lcd_st_pkt_arbiter.sv
// Bench for lcd_st_pkt_arbiter: directed scenarios plus randomized traffic against a packet-level reference model.
// Counter checks are built when LCD_PKT_ARB_CNT_EN is defined.
module tb_lcd_st_pkt_arbiter;
  localparam int DATA_W  = 64;
  localparam int EMPTY_W = 3;
  localparam int CNT_W   = 2;

  typedef struct packed {
    logic [63:0] data;
    logic        sop;
    logic        eop;
    logic [2:0]  empty;
  } beat_t;

  logic               clk = 1'b0;
  logic               reset_n;
  logic               in0_ready, in1_ready;
  logic               in0_valid, in1_valid;
  logic [DATA_W-1:0]  in0_data, in1_data;
  logic               in0_startofpacket, in1_startofpacket;
  logic               in0_endofpacket, in1_endofpacket;
  logic [EMPTY_W-1:0] in0_empty, in1_empty;
  logic               out_ready;
  logic               out_valid;
  logic [DATA_W-1:0]  out_data;
  logic               out_startofpacket, out_endofpacket;
  logic [EMPTY_W-1:0] out_empty;
  logic [1:0]         grant;
  logic               err_orphan;
`ifdef LCD_PKT_ARB_CNT_EN
  logic [CNT_W-1:0]   pkt_cnt0, pkt_cnt1;
`endif

  lcd_st_pkt_arbiter #(
    .DATA_W(DATA_W), .EMPTY_W(EMPTY_W), .CNT_W(CNT_W), .RR_INIT(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .in0_ready(in0_ready), .in0_valid(in0_valid), .in0_data(in0_data),
    .in0_startofpacket(in0_startofpacket), .in0_endofpacket(in0_endofpacket), .in0_empty(in0_empty),
    .in1_ready(in1_ready), .in1_valid(in1_valid), .in1_data(in1_data),
    .in1_startofpacket(in1_startofpacket), .in1_endofpacket(in1_endofpacket), .in1_empty(in1_empty),
    .out_ready(out_ready), .out_valid(out_valid), .out_data(out_data),
    .out_startofpacket(out_startofpacket), .out_endofpacket(out_endofpacket), .out_empty(out_empty),
    .grant(grant), .err_orphan(err_orphan)
`ifdef LCD_PKT_ARB_CNT_EN
    , .pkt_cnt0(pkt_cnt0), .pkt_cnt1(pkt_cnt1)
`endif
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: owner -1 = nobody, else source index; pref = source that wins a tie.
  int    owner, pref, cycle, orphans;
  int    cnt_exp [2];
  int    delivered [2];
  bit    exp_err;
  beat_t q0[$], q1[$];
  beat_t pb [2];
  bit    hold [2];
  int    vprob, rprob;
  bit    rtoggle;
  int          log_cyc[$];
  logic [63:0] log_data[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic beat_t mk(input logic [63:0] d, input bit s, input bit e, input logic [2:0] m);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = m;
    return b;
  endfunction

  task automatic push(input int s, input beat_t b);
    if (s == 0) q0.push_back(b); else q1.push_back(b);
  endtask

  // n-beat packet with data base+1 .. base+n
  task automatic push_pkt(input int s, input logic [63:0] base, input int n);
    for (int i = 1; i <= n; i++) push(s, mk(base + 64'(i), i == 1, i == n, 3'(i)));
  endtask

  function automatic int qsize(input int s);
    return (s == 0) ? q0.size() : q1.size();
  endfunction

  task automatic drive_inputs();
    in0_valid = hold[0]; in0_data = pb[0].data; in0_startofpacket = pb[0].sop;
    in0_endofpacket = pb[0].eop; in0_empty = pb[0].empty;
    in1_valid = hold[1]; in1_data = pb[1].data; in1_startofpacket = pb[1].sop;
    in1_endofpacket = pb[1].eop; in1_empty = pb[1].empty;
  endtask

  task automatic run_cycle();
    logic        ev, es, ee;
    logic [63:0] ed;
    logic [2:0]  em;
    logic [1:0]  eg, er;
    bit          nerr;
    int          o;
    @(posedge clk); #2;
    cycle++;
    for (int s = 0; s < 2; s++) begin
      if (!hold[s]) begin
        if (qsize(s) > 0 && $urandom_range(99) < vprob) begin
          pb[s]   = (s == 0) ? q0[0] : q1[0];
          hold[s] = 1'b1;
        end else begin
          pb[s] = '0;
        end
      end
    end
    drive_inputs();
    out_ready = rtoggle ? ~out_ready : ($urandom_range(99) < rprob);
    #1;
    o = owner;
    if (o < 0) begin
      ev = 0; ed = '0; es = 0; ee = 0; em = '0; eg = 2'b00;
      er = {hold[1] & ~pb[1].sop, hold[0] & ~pb[0].sop};
    end else begin
      ev = hold[o]; ed = pb[o].data; es = pb[o].sop; ee = pb[o].eop; em = pb[o].empty;
      eg = (o == 0) ? 2'b01 : 2'b10;
      er = (o == 0) ? {1'b0, out_ready} : {out_ready, 1'b0};
    end
    chk("out_valid", 64'(out_valid), 64'(ev));
    chk("out_data", out_data, ed);
    chk("out_sop", 64'(out_startofpacket), 64'(es));
    chk("out_eop", 64'(out_endofpacket), 64'(ee));
    chk("out_empty", 64'(out_empty), 64'(em));
    chk("grant", 64'(grant), 64'(eg));
    chk("in0_ready", 64'(in0_ready), 64'(er[0]));
    chk("in1_ready", 64'(in1_ready), 64'(er[1]));
    chk("err_orphan", 64'(err_orphan), 64'(exp_err));
`ifdef LCD_PKT_ARB_CNT_EN
    chk("pkt_cnt0", 64'(pkt_cnt0), 64'(cnt_exp[0]));
    chk("pkt_cnt1", 64'(pkt_cnt1), 64'(cnt_exp[1]));
`endif
    // Advance the model using the beats presented this cycle.
    nerr = 0;
    if (o < 0) begin
      if (hold[0] && pb[0].sop && hold[1] && pb[1].sop) owner = pref;
      else if (hold[0] && pb[0].sop) owner = 0;
      else if (hold[1] && pb[1].sop) owner = 1;
    end else if (hold[o] && out_ready) begin
      log_cyc.push_back(cycle);
      log_data.push_back(pb[o].data);
      delivered[o]++;
      if (pb[o].eop) begin
        cnt_exp[o] = (cnt_exp[o] + 1) % (1 << CNT_W);
        pref  = 1 - o;
        owner = -1;
      end
    end
    for (int s = 0; s < 2; s++) begin
      if (hold[s] && er[s]) begin
        if (o < 0) begin
          orphans++;
          nerr = 1;
        end
        if (s == 0) void'(q0.pop_front()); else void'(q1.pop_front());
        hold[s] = 0;
      end
    end
    exp_err = nerr;
  endtask

  task automatic model_reset();
    owner = -1; pref = 0; exp_err = 0;
    cnt_exp[0] = 0; cnt_exp[1] = 0;
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    reset_n = 1'b0;
    q0.delete(); q1.delete();
    hold[0] = 0; hold[1] = 0; pb[0] = '0; pb[1] = '0;
    drive_inputs();
    out_ready = 1'b0; rtoggle = 0;
    model_reset();
    #1;
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_err_orphan", 64'(err_orphan), 64'd0);
    #5 reset_n = 1'b1;
  endtask

  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) run_cycle();
  endtask

  task automatic clear_log();
    log_cyc.delete(); log_data.delete();
  endtask

  initial begin
    int  base;
    bit  done;
    reset_n = 1'b0;
    cycle = 0; orphans = 0; delivered[0] = 0; delivered[1] = 0;
    vprob = 100; rprob = 100; rtoggle = 0;
    do_reset();

    // Four-beat packet from in0, then rr pointer favours in1.
    push_pkt(0, 64'h0, 4);
    clear_log();
    base = cycle + 1;
    run_n(6);
    chk("t1_beats", 64'(log_data.size()), 64'd4);
    for (int i = 0; i < 4 && i < log_data.size(); i++) begin
      chk("t1_data", log_data[i], 64'(i + 1));
      chk("t1_cycle", 64'(log_cyc[i] - base), 64'(i + 1));
    end
    clear_log();
    push_pkt(0, 64'h10, 1);
    push_pkt(1, 64'h20, 1);
    run_n(5);
    chk("t1_rr_count", 64'(log_data.size()), 64'd2);
    if (log_data.size() == 2) begin
      chk("t1_rr_first", log_data[0], 64'h21);
      chk("t1_rr_second", log_data[1], 64'h11);
      chk("t1_rr_bubble", 64'(log_cyc[1] - log_cyc[0]), 64'd2);
    end

    // Simultaneous SOP after reset: in0 first, in1 after one bubble.
    do_reset();
    clear_log();
    push_pkt(0, 64'hA0, 2);
    push_pkt(1, 64'hB0, 2);
    run_n(8);
    chk("t2_count", 64'(log_data.size()), 64'd4);
    if (log_data.size() == 4) begin
      chk("t2_a1", log_data[0], 64'hA1);
      chk("t2_a2", log_data[1], 64'hA2);
      chk("t2_b1", log_data[2], 64'hB1);
      chk("t2_b2", log_data[3], 64'hB2);
      chk("t2_bubble", 64'(log_cyc[2] - log_cyc[1]), 64'd2);
    end

    // Backpressure toggling every cycle.
    clear_log();
    rtoggle = 1;
    push_pkt(0, 64'hC0, 3);
    run_n(10);
    rtoggle = 0;
    chk("t3_count", 64'(log_data.size()), 64'd3);
    for (int i = 0; i < 3 && i < log_data.size(); i++)
      chk("t3_data", log_data[i], 64'hC1 + 64'(i));

    // Orphan beat from in1 in IDLE.
    clear_log();
    push(1, mk(64'hD1, 1'b0, 1'b1, 3'd0));
    run_n(3);
    chk("t4_orphans", 64'(orphans), 64'd1);
    chk("t4_nothing_out", 64'(log_data.size()), 64'd0);

    // Reset after beat 2 of a 4-beat packet; remaining beats become orphans.
    clear_log();
    push_pkt(0, 64'hE0, 4);
    run_n(3);
    chk("t5_pre_beats", 64'(log_data.size()), 64'd2);
    @(posedge clk); #2;
    hold[0] = 0; pb[0] = '0; hold[1] = 0; pb[1] = '0;
    drive_inputs();
    #1;
    chk("t5_owned", 64'(grant), 64'd1);
    reset_n = 1'b0;
    #1;
    chk("t5_rst_grant", 64'(grant), 64'd0);
    chk("t5_rst_valid", 64'(out_valid), 64'd0);
    reset_n = 1'b1;
    model_reset();
    run_n(4);
    chk("t5_orphans", 64'(orphans), 64'd3);
    chk("t5_beats", 64'(log_data.size()), 64'd2);

`ifdef LCD_PKT_ARB_CNT_EN
    // Five packets from in0 wrap a 2-bit counter to 1.
    do_reset();
    push_pkt(0, 64'h50, 1);
    push_pkt(0, 64'h60, 2);
    push_pkt(0, 64'h70, 1);
    push_pkt(0, 64'h80, 1);
    push_pkt(0, 64'h90, 2);
    run_n(20);
    chk("t6_cnt0", 64'(pkt_cnt0), 64'd1);
    chk("t6_cnt1", 64'(pkt_cnt1), 64'd0);
`endif

    // Randomized traffic.
    do_reset();
    delivered[0] = 0; delivered[1] = 0;
    base = 0;
    for (int s = 0; s < 2; s++)
      for (int p = 0; p < 20; p++) begin
        int n;
        n = int'($urandom_range(4, 1));
        base += n;
        for (int i = 1; i <= n; i++)
          push(s, mk({$urandom, $urandom}, i == 1, i == n, 3'($urandom_range(7))));
      end
    vprob = 60; rprob = 70;
    done = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      run_cycle();
      done = (q0.size() == 0) && (q1.size() == 0) && (owner < 0);
    end
    chk("rand_drained", 64'(done), 64'd1);
    chk("rand_delivered", 64'(delivered[0] + delivered[1]), 64'(base));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
